alu_share_arbiter: RTL and testbench

//   Shares one combinational 32-bit integer ALU between two requesters (req0: integer pipeline,
//   req1: address/CSR helper). Arbitrates with valid/ready handshakes, drives the ALU, and

---
 rtl/alu_share_arbiter.sv | 134 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters with a tagged one-entry response buffer.
// Optional round-robin arbitration via `define ALU_ARB_ROUND_ROBIN_EN (fixed priority otherwise).
module alu_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req0_valid_i,
    output logic                  req0_ready_o,
    input  logic [DATA_WIDTH-1:0] req0_op1_i,
    input  logic [DATA_WIDTH-1:0] req0_op2_i,
    input  logic [OP_WIDTH-1:0]   req0_operation_i,
    input  logic                  req1_valid_i,
    output logic                  req1_ready_o,
    input  logic [DATA_WIDTH-1:0] req1_op1_i,
    input  logic [DATA_WIDTH-1:0] req1_op2_i,
    input  logic [OP_WIDTH-1:0]   req1_operation_i,
    output logic [DATA_WIDTH-1:0] alu_op1_o,
    output logic [DATA_WIDTH-1:0] alu_op2_o,
    output logic [OP_WIDTH-1:0]   alu_operation_o,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    input  logic                  alu_zero_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_id_o,
    output logic [DATA_WIDTH-1:0] rsp_result_o,
    output logic                  rsp_zero_o,
    output logic [CNT_WIDTH-1:0]  grant0_cnt_o,
    output logic [CNT_WIDTH-1:0]  grant1_cnt_o
);

    typedef enum logic {
        EMPTY,
        FULL
    } buf_state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    buf_state_t state, state_next;
    logic       can_accept;
    logic       win0, win1;
    logic       accept;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic rr_ptr;

    // Pointer names the preferred requester; a lone valid wins regardless.
    assign win0 = req0_valid_i & (~req1_valid_i | ~rr_ptr);
    assign win1 = req1_valid_i & (~req0_valid_i | rr_ptr);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr <= 1'b0;
        end else if (accept) begin
            rr_ptr <= ~req1_ready_o;
        end
    end
`else
    assign win0 = req0_valid_i;
    assign win1 = req1_valid_i & ~req0_valid_i;
`endif

    assign rsp_valid_o  = (state == FULL);
    assign can_accept   = ~rsp_valid_o | rsp_ready_i;
    assign req0_ready_o = win0 & can_accept & ~rst_i;
    assign req1_ready_o = win1 & can_accept & ~rst_i;
    assign accept       = req0_ready_o | req1_ready_o;

    always_comb begin
        alu_op1_o       = '0;
        alu_op2_o       = '0;
        alu_operation_o = '0;
        unique case (1'b1)
            win0: begin
                alu_op1_o       = req0_op1_i;
                alu_op2_o       = req0_op2_i;
                alu_operation_o = req0_operation_i;
            end
            win1: begin
                alu_op1_o       = req1_op1_i;
                alu_op2_o       = req1_op2_i;
                alu_operation_o = req1_operation_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (accept) state_next = FULL;
            FULL:  if (!accept && rsp_ready_i) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_id_o     <= 1'b0;
            rsp_result_o <= '0;
            rsp_zero_o   <= 1'b0;
        end else if (accept) begin
            rsp_id_o     <= req1_ready_o;
            rsp_result_o <= alu_result_i;
            rsp_zero_o   <= alu_zero_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            grant0_cnt_o <= '0;
            grant1_cnt_o <= '0;
        end else begin
            if (req0_ready_o && grant0_cnt_o != CNT_MAX) begin
                grant0_cnt_o <= grant0_cnt_o + CNT_ONE;
            end
            if (req1_ready_o && grant1_cnt_o != CNT_MAX) begin
                grant1_cnt_o <= grant1_cnt_o + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: bench-side ALU, reference arbitration model,
// directed scenarios followed by randomized handshaking traffic.
module tb_alu_share_arbiter;

    localparam int DW = 32;
    localparam int OW = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          req0_valid_i, req1_valid_i;
    logic          req0_ready_o, req1_ready_o;
    logic [DW-1:0] req0_op1_i, req0_op2_i, req1_op1_i, req1_op2_i;
    logic [OW-1:0] req0_operation_i, req1_operation_i;
    logic [DW-1:0] alu_op1_o, alu_op2_o, alu_result_i;
    logic [OW-1:0] alu_operation_o;
    logic          alu_zero_i;
    logic          rsp_valid_o, rsp_ready_i, rsp_id_o, rsp_zero_o;
    logic [DW-1:0] rsp_result_o;
    logic [CW-1:0] grant0_cnt_o, grant1_cnt_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          id;
        logic [DW-1:0] res;
        logic          z;
    } exp_t;

    exp_t sb[$];

    bit m_init = 0;
    bit m_full = 0;
    bit m_ptr  = 0;
    int m_cnt0 = 0;
    int m_cnt1 = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(
        .DATA_WIDTH(DW),
        .OP_WIDTH  (OW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .req0_valid_i    (req0_valid_i),
        .req0_ready_o    (req0_ready_o),
        .req0_op1_i      (req0_op1_i),
        .req0_op2_i      (req0_op2_i),
        .req0_operation_i(req0_operation_i),
        .req1_valid_i    (req1_valid_i),
        .req1_ready_o    (req1_ready_o),
        .req1_op1_i      (req1_op1_i),
        .req1_op2_i      (req1_op2_i),
        .req1_operation_i(req1_operation_i),
        .alu_op1_o       (alu_op1_o),
        .alu_op2_o       (alu_op2_o),
        .alu_operation_o (alu_operation_o),
        .alu_result_i    (alu_result_i),
        .alu_zero_i      (alu_zero_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
        .rsp_id_o        (rsp_id_o),
        .rsp_result_o    (rsp_result_o),
        .rsp_zero_o      (rsp_zero_o),
        .grant0_cnt_o    (grant0_cnt_o),
        .grant1_cnt_o    (grant1_cnt_o)
    );

    function automatic logic [DW-1:0] alu_ref(input logic [OW-1:0] op,
                                              input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLL:  return a << b[4:0];
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            OP_XOR:  return a ^ b;
            OP_SRL:  return a >> b[4:0];
            OP_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            default: return '0;
        endcase
    endfunction

    // Bench-side combinational ALU
    assign alu_result_i = alu_ref(alu_operation_o, alu_op1_o, alu_op2_o);
    assign alu_zero_i   = (alu_result_i == '0);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: predicts grants, buffer occupancy and counters
    always @(negedge clk) begin
        bit            can, wv, w, r0, r1;
        logic [DW-1:0] e1, e2;
        logic [OW-1:0] eo;
        exp_t          e;
        if (m_init) begin
            chk("rsp_valid", rsp_valid_o, m_full);
            chk("grant0_cnt", grant0_cnt_o, m_cnt0);
            chk("grant1_cnt", grant1_cnt_o, m_cnt1);
        end
        can = !m_full || rsp_ready_i;
        wv  = req0_valid_i || req1_valid_i;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        if (req0_valid_i && req1_valid_i) w = m_ptr;
        else w = req1_valid_i;
`else
        w = !req0_valid_i;
`endif
        r0 = wv && !w && can && !rst_i;
        r1 = wv && w && can && !rst_i;
        e1 = !wv ? '0 : (w ? req1_op1_i : req0_op1_i);
        e2 = !wv ? '0 : (w ? req1_op2_i : req0_op2_i);
        eo = !wv ? '0 : (w ? req1_operation_i : req0_operation_i);
        if (m_init || rst_i) begin
            chk("req0_ready", req0_ready_o, r0);
            chk("req1_ready", req1_ready_o, r1);
        end
        if (m_init) begin
            chk("alu_op1", alu_op1_o, e1);
            chk("alu_op2", alu_op2_o, e2);
            chk("alu_operation", alu_operation_o, eo);
        end
        if (rst_i) begin
            m_init = 1;
            m_full = 0;
            m_ptr  = 0;
            m_cnt0 = 0;
            m_cnt1 = 0;
            sb.delete();
        end else if (m_init) begin
            if (r0 || r1) begin
                e.id  = w;
                e.res = alu_ref(eo, e1, e2);
                e.z   = (e.res == '0);
                sb.push_back(e);
                m_ptr = !w;
                if (!w && m_cnt0 < CMAX) m_cnt0++;
                if (w && m_cnt1 < CMAX) m_cnt1++;
            end
            m_full = (r0 || r1) || (m_full && !rsp_ready_i);
        end
    end

    // Monitor: compares the presented response with the oldest expected entry
    always @(negedge clk) begin
        if (m_init && !rst_i && rsp_valid_o) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                chk("rsp_id", rsp_id_o, sb[0].id);
                chk("rsp_result", rsp_result_o, sb[0].res);
                chk("rsp_zero", rsp_zero_o, sb[0].z);
                if (rsp_ready_i) void'(sb.pop_front());
            end
        end
    end

    task automatic drive(input bit v0, input logic [3:0] o0,
                         input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                         input bit v1, input logic [3:0] o1,
                         input logic [DW-1:0] a1, input logic [DW-1:0] b1,
                         input bit rr);
        req0_valid_i = v0; req0_operation_i = o0;
        req0_op1_i = a0;   req0_op2_i = b0;
        req1_valid_i = v1; req1_operation_i = o1;
        req1_op1_i = a1;   req1_op2_i = b1;
        rsp_ready_i = rr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    function automatic logic [3:0] rand_op();
        logic [3:0] ops [10];
        ops = '{OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
                OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND};
        return ops[$urandom_range(0, 9)];
    endfunction

    initial begin
        bit a0, a1;
        logic [DW-1:0] x;
        rst_i = 1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_i = 0;
        // basic add, then held SUB with back-pressure
        drive(1, OP_ADD, 5, 7, 0, 0, 0, 0, 1);
        idle(1);
        drive(1, OP_SUB, 9, 9, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, OP_ADD, 1, 2, 1, OP_OR, 3, 4, 0);
        drive(1, OP_ADD, 1, 2, 1, OP_OR, 3, 4, 1);
        idle(2);
        // both requesters contending
        for (int i = 0; i < 4; i++)
            drive(1, OP_XOR, 32'hA5, i, 1, OP_AND, 32'hFF, i + 1, 1);
        idle(2);
        // back-to-back from requester 1
        drive(0, 0, 0, 0, 1, OP_SLT, 32'hFFFF_FFFF, 1, 1);
        drive(0, 0, 0, 0, 1, OP_XOR, 32'hF0, 32'hFF, 1);
        idle(2);
        // reset while the buffer is full
        drive(1, OP_ADD, 3, 4, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_i = 1;
        drive(1, OP_ADD, 8, 8, 1, OP_SUB, 8, 8, 0);
        rst_i = 0;
        idle(1);
        // saturate the requester-0 counter
        for (int i = 0; i < CMAX + 5; i++) drive(1, OP_ADD, i, 1, 0, 0, 0, 0, 1);
        idle(2);
        // randomized traffic; operands held until accepted
        req0_valid_i = 0;
        req1_valid_i = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            a0 = req0_valid_i && req0_ready_o;
            a1 = req1_valid_i && req1_ready_o;
            @(posedge clk);
            #1;
            rst_i = ($urandom_range(0, 199) == 0);
            if (!req0_valid_i || a0) begin
                req0_valid_i = $urandom_range(0, 1);
                req0_operation_i = rand_op();
                x = $urandom;
                req0_op1_i = x;
                req0_op2_i = ($urandom_range(0, 3) == 0) ? x : $urandom;
            end
            if (!req1_valid_i || a1) begin
                req1_valid_i = $urandom_range(0, 1);
                req1_operation_i = rand_op();
                req1_op1_i = $urandom;
                req1_op2_i = $urandom_range(0, 40);
            end
            rsp_ready_i = ($urandom_range(0, 9) < 7);
        end
        rst_i = 0;
        idle(4);
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
